regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 147 ++++++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two combinational read ports,
// two synchronous write ports, optional write-to-read bypass, optional
// hardwired zero register, and a sequential clear engine started by reset.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   ra_addr / ra_data  read port A (combinational data)
//   rb_addr / rb_data  read port B (combinational data)
//   wa_en/addr/data    write port A
//   wb_en/addr/data    write port B (wins on address collision)
//   busy               registered, high while the clear engine runs
//   wr_drop            registered one-cycle pulse: write requested while busy
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            wr_drop
);

  localparam logic [0:0]    S_CLEAR = 1'b0;
  localparam logic [0:0]    S_RUN   = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  logic [0:0]      r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_wr_drop;
  logic [XLEN-1:0] r_mem [NREGS];

  logic [0:0]      w_state_nxt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_busy_nxt;
  logic            w_drop_nxt;
  logic            w_clr_we;
  logic            w_wa_ok;
  logic            w_wb_ok;

  // Next-state logic for the clear engine and the registered status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_drop_nxt  = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we   = 1'b1;
        w_cnt_nxt  = r_cnt + AW'(1);
        w_drop_nxt = wa_en | wb_en;
        if (r_cnt == LAST) begin
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  // State register; reset restarts the clear from entry 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_drop <= w_drop_nxt;
    end
  end

  // A write to register 0 is dropped per port, leaving the other port intact
  assign w_wa_ok = wa_en && (r_state == S_RUN) && !((ZERO_REG != 0) && (wa_addr == '0));
  assign w_wb_ok = wb_en && (r_state == S_RUN) && !((ZERO_REG != 0) && (wb_addr == '0));

  // Storage array; untouched by the reset edge itself. Port B is assigned
  // last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_wa_ok) r_mem[wa_addr] <= wa_data;
        if (w_wb_ok) r_mem[wb_addr] <= wb_data;
      end
    end
  end

  // Read mux: masked while busy, zero register, then B-over-A bypass
  function automatic logic [XLEN-1:0] f_read(
    input logic [AW-1:0]   rd_addr,
    input logic [XLEN-1:0] stored,
    input logic            blk,
    input logic            pa_en,
    input logic [AW-1:0]   pa_addr,
    input logic [XLEN-1:0] pa_data,
    input logic            pb_en,
    input logic [AW-1:0]   pb_addr,
    input logic [XLEN-1:0] pb_data
  );
    logic [XLEN-1:0] v;
    v = stored;
    if (blk) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && pb_en && (pb_addr == rd_addr)) begin
      v = pb_data;
    end else if ((BYPASS != 0) && pa_en && (pa_addr == rd_addr)) begin
      v = pa_data;
    end
    return v;
  endfunction

  assign ra_data = f_read(ra_addr, r_mem[ra_addr], r_busy,
                          wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data);
  assign rb_data = f_read(rb_addr, r_mem[rb_addr], r_busy,
                          wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data);

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: dut0 uses defaults (32x32, zero reg, bypass);
// dut1 uses XLEN=64, NREGS=8, no zero reg, no bypass. Stimulus pushes
// expected values into a queue; a negedge monitor pops and compares.
module tb_regfile_mp;

  localparam int S_RA0 = 0, S_RB0 = 1, S_RA1 = 2, S_RB1 = 3,
                 S_BUSY0 = 4, S_DROP0 = 5, S_BUSY1 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic clk, rst_n;

  logic [4:0]  ra0_addr, rb0_addr, wa0_addr, wb0_addr;
  logic [31:0] ra0_data, rb0_data, wa0_data, wb0_data;
  logic        wa0_en, wb0_en, busy0, drop0;

  logic [2:0]  ra1_addr, rb1_addr, wa1_addr, wb1_addr;
  logic [63:0] ra1_data, rb1_data, wa1_data, wb1_data;
  logic        wa1_en, wb1_en, busy1, drop1;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  regfile_mp u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra0_addr), .ra_data(ra0_data),
    .rb_addr(rb0_addr), .rb_data(rb0_data),
    .wa_en(wa0_en), .wa_addr(wa0_addr), .wa_data(wa0_data),
    .wb_en(wb0_en), .wb_addr(wb0_addr), .wb_data(wb0_data),
    .busy(busy0), .wr_drop(drop0)
  );

  regfile_mp #(.XLEN(64), .NREGS(8), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra1_addr), .ra_data(ra1_data),
    .rb_addr(rb1_addr), .rb_data(rb1_data),
    .wa_en(wa1_en), .wa_addr(wa1_addr), .wa_data(wa1_data),
    .wb_en(wb1_en), .wb_addr(wb1_addr), .wb_data(wb1_data),
    .busy(busy1), .wr_drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_v(input string name, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, compare everything queued this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sel)
        S_RA0:   act = {32'h0, ra0_data};
        S_RB0:   act = {32'h0, rb0_data};
        S_RA1:   act = ra1_data;
        S_RB1:   act = rb1_data;
        S_BUSY0: act = {63'h0, busy0};
        S_DROP0: act = {63'h0, drop0};
        S_BUSY1: act = {63'h0, busy1};
        default: act = 64'hx;
      endcase
      chk(e.name, act, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    rst_n = 1'b0;
    ra0_addr = '0; rb0_addr = '0; wa0_addr = '0; wb0_addr = '0;
    wa0_data = '0; wb0_data = '0; wa0_en = 1'b0; wb0_en = 1'b0;
    ra1_addr = '0; rb1_addr = '0; wa1_addr = '0; wb1_addr = '0;
    wa1_data = '0; wb1_data = '0; wa1_en = 1'b0; wb1_en = 1'b0;

    // Reset held for two edges
    step();
    step();
    expect_v("rst_busy0", S_BUSY0, 64'd1);
    expect_v("rst_busy1", S_BUSY1, 64'd1);
    expect_v("rst_drop0", S_DROP0, 64'd0);
    expect_v("rst_ra0",   S_RA0,   64'd0);
    rst_n = 1'b1;

    // Clear duration: 32 edges for dut0, 8 for dut1
    n0 = 0; n1 = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (!busy1 && n1 == 0) n1 = n;
      if (!busy0) begin
        n0 = n;
        break;
      end
    end
    chk("busy_len_32", 64'(n0), 64'd32);
    chk("busy_len_8",  64'(n1), 64'd8);

    // Every entry reads zero after the clear
    for (int i = 0; i < 32; i++) begin
      ra0_addr = 5'(i);
      rb0_addr = 5'(31 - i);
      expect_v("clr_ra0", S_RA0, 64'd0);
      expect_v("clr_rb0", S_RB0, 64'd0);
      if (i < 8) begin
        ra1_addr = 3'(i);
        rb1_addr = 3'(7 - i);
        expect_v("clr_ra1", S_RA1, 64'd0);
        expect_v("clr_rb1", S_RB1, 64'd0);
      end
      step();
    end

    // Same-address collision: port B wins (bypass and stored)
    wa0_en = 1'b1; wa0_addr = 5'd5; wa0_data = 32'h11111111;
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h22222222;
    ra0_addr = 5'd5;
    expect_v("coll_byp", S_RA0, 64'h22222222);
    step();
    wa0_en = 1'b0; wb0_en = 1'b0;
    expect_v("coll_mem", S_RA0, 64'h22222222);
    step();

    // Independent dual write
    wa0_en = 1'b1; wa0_addr = 5'd3; wa0_data = 32'hA5A5A5A5;
    wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h5A5A5A5A;
    step();
    wa0_en = 1'b0; wb0_en = 1'b0;
    ra0_addr = 5'd3; rb0_addr = 5'd4;
    expect_v("dual_a", S_RA0, 64'hA5A5A5A5);
    expect_v("dual_b", S_RB0, 64'h5A5A5A5A);
    step();

    // Bypass on dut0; no bypass on dut1
    wa0_en = 1'b1; wa0_addr = 5'd7; wa0_data = 32'hDEADBEEF; ra0_addr = 5'd7;
    wa1_en = 1'b1; wa1_addr = 3'd7; wa1_data = 64'h00000000DEADBEEF; ra1_addr = 3'd7;
    expect_v("byp_on",  S_RA0, 64'hDEADBEEF);
    expect_v("byp_off", S_RA1, 64'h0);
    step();
    wa0_en = 1'b0;
    wa1_data = 64'h0123456789ABCDEF;
    expect_v("byp_on_mem",  S_RA0, 64'hDEADBEEF);
    expect_v("byp_off_mem", S_RA1, 64'h00000000DEADBEEF);
    step();
    wa1_en = 1'b0;
    expect_v("x64_r7", S_RA1, 64'h0123456789ABCDEF);
    step();

    // Zero register: dut0 ignores, other port still writes; dut1 stores
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFFFFFF; rb0_addr = 5'd0;
    wa0_en = 1'b1; wa0_addr = 5'd9; wa0_data = 32'h00000099; ra0_addr = 5'd9;
    wb1_en = 1'b1; wb1_addr = 3'd0; wb1_data = 64'h00000000FFFFFFFF; rb1_addr = 3'd0;
    expect_v("zr_byp",     S_RB0, 64'h0);
    expect_v("zr_other",   S_RA0, 64'h99);
    expect_v("nozr_old",   S_RB1, 64'h0);
    step();
    wa0_en = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
    expect_v("zr_mem",     S_RB0, 64'h0);
    expect_v("zr_other_m", S_RA0, 64'h99);
    expect_v("nozr_mem",   S_RB1, 64'h00000000FFFFFFFF);
    step();

    // Reset, then abort the clear once cnt reaches 10
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 2) begin
        ra0_addr = 5'd5;
        expect_v("busy_mask", S_RA0, 64'h0);
        expect_v("busy_mid",  S_BUSY0, 64'd1);
      end
    end
    rst_n = 1'b0;
    step();
    expect_v("midrst_busy", S_BUSY0, 64'd1);
    rst_n = 1'b1;

    // Full restart; a write during the clear is dropped and flagged
    n0 = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 4) begin
        wa0_en = 1'b1; wa0_addr = 5'd2; wa0_data = 32'hCAFEF00D;
      end else begin
        wa0_en = 1'b0;
      end
      if (n == 5) expect_v("drop_pulse", S_DROP0, 64'd1);
      if (n == 6) expect_v("drop_clear", S_DROP0, 64'd0);
      if (!busy0) begin
        n0 = n;
        break;
      end
    end
    chk("restart_len_32", 64'(n0), 64'd32);

    ra0_addr = 5'd2; rb0_addr = 5'd5; ra1_addr = 3'd7;
    expect_v("drop_target", S_RA0, 64'h0);
    expect_v("recleared5",  S_RB0, 64'h0);
    expect_v("recleared_x", S_RA1, 64'h0);
    expect_v("run_drop",    S_DROP0, 64'd0);
    step();

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
